// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I fetch front end.
// Fetch FSM states are plain 1-bit constants so older blocks can compare against them directly.
package rv32i_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  localparam logic [0:0] FETCH_RUN   = 1'b0;
  localparam logic [0:0] FETCH_FAULT = 1'b1;

  function automatic logic misaligned(input logic [1:0] lsbs);
    return (lsbs & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/rv32i_fetch_fifo.sv
// Small synchronous FIFO buffering fetched {inst, pc} pairs; flush has priority over push/pop.
// The head is taken straight from storage registers, so no input reaches it combinationally.
module rv32i_fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    do_pop  = pop & ~empty;
    do_push = push & ((count_q != CW'(DEPTH)) | do_pop);
    head    = mem_q[rptr_q];
    count   = count_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (do_pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction-fetch front end: PC, SRAM request issue, fetch buffer and decode handshake.
// A redirect flushes the buffer and drops any response arriving in the same cycle.
module rv32i_fetch_unit #(
  parameter int unsigned      XLEN       = rv32i_pkg::XLEN,
  parameter int unsigned      IMEM_AW    = 8,
  parameter logic [XLEN-1:0]  RESET_PC   = rv32i_pkg::RESET_PC,
  parameter int unsigned      FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               inst_ready,
  output logic               inst_valid,
  output logic [31:0]        inst,
  output logic [XLEN-1:0]    pc,
  output logic [XLEN-1:0]    pc_plus_four,
  output logic               fetch_fault,
  output logic               imem_csb,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_dout
);

  import rv32i_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UW = CW + 1;

  logic [XLEN-1:0]    fpc_q, ifpc_q;
  logic               inflight_q;
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      count;
  logic               fifo_empty;
  logic [XLEN+31:0]   head;
  logic               pop, issue, redirect_bad;
  logic [UW-1:0]      credit_used;

  always_comb begin
    redirect_bad = misaligned(redirect_pc[1:0]);
    inst_valid   = (state_q == FETCH_RUN) & ~fifo_empty;
    pop          = inst_valid & inst_ready;
    // Entries already buffered plus the one returning, less the one leaving this cycle.
    credit_used  = UW'(count) + UW'(inflight_q) - UW'(pop);
    issue        = ~reset & (state_q == FETCH_RUN) & ~redirect_valid &
                   (credit_used < UW'(FIFO_DEPTH));
    imem_csb     = ~issue;
    imem_addr    = fpc_q[IMEM_AW+1:2];
    fetch_fault  = (state_q == FETCH_FAULT);
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = redirect_bad ? FETCH_FAULT : FETCH_RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc_q      <= RESET_PC;
      ifpc_q     <= '0;
      inflight_q <= 1'b0;
      state_q    <= FETCH_RUN;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      if (redirect_valid) begin
        if (!redirect_bad) fpc_q <= redirect_pc;
      end else if (issue) begin
        ifpc_q <= fpc_q;
        fpc_q  <= fpc_q + XLEN'(4);
      end
    end
  end

  rv32i_fetch_fifo #(
    .WIDTH (XLEN + 32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (redirect_valid),
    .push  (inflight_q),
    .wdata ({imem_dout, ifpc_q}),
    .pop   (pop),
    .head  (head),
    .count (count),
    .empty (fifo_empty)
  );

  always_comb begin
    inst         = '0;
    pc           = '0;
    pc_plus_four = '0;
    if (inst_valid) begin
      inst         = head[XLEN+31:XLEN];
      pc           = head[XLEN-1:0];
      pc_plus_four = head[XLEN-1:0] + XLEN'(4);
    end
  end

endmodule
